// File: rtl/clk_ratio_meter_pkg.sv
// Shared types and defaults for the clock ratio meter and its input synchronizer.
package clk_ratio_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEAS_HI = 2'd2,
    ST_MEAS_LO = 2'd3
  } state_e;

  localparam int DEF_WIDTH       = 24;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_ratio_meter_sync_edge_det.sv
// Multi-flop synchronizer followed by one edge register; rise/fall share the same latency.
module sync_edge_det
  import clk_ratio_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~prev_q;
  assign fall  = ~sig_s & prev_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of an asynchronous pulse input in clk cycles.
// Build option: CLK_RATIO_METER_CONT_EN selects back-to-back continuous measurement.
//
// state      | meaning
// IDLE       | waiting for start, edges ignored
// ARM        | waiting for the first rising edge
// MEAS_HI    | counting the high phase
// MEAS_LO    | counting the low phase until the closing rise
module clk_ratio_meter
  import clk_ratio_meter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_cnt,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic             sync_unused;
  logic             rise;
  logic             fall;
  logic             cnt_sat;
  logic [WIDTH-1:0] cnt_inc;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .sig_s (sync_unused),
    .rise  (rise),
    .fall  (fall)
  );

  assign cnt_sat = (cnt_q == CNT_MAX);
  // Saturate so a fall landing on the last count cannot wrap the low-phase counter.
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_d     = high_q;
    period_d   = period_q;
    high_cnt_d = high_cnt_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = ST_MEAS_HI;
        end else if (cnt_sat) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_MEAS_HI: begin
        if (fall) begin
          high_d  = cnt_q;
          cnt_d   = cnt_inc;
          state_d = ST_MEAS_LO;
        end else if (cnt_sat) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_MEAS_LO: begin
        if (rise) begin
          period_d   = cnt_q;
          high_cnt_d = high_q;
          valid_d    = 1'b1;
`ifdef CLK_RATIO_METER_CONT_EN
          cnt_d      = CNT_ONE;
          state_d    = ST_MEAS_HI;
`else
          state_d    = ST_IDLE;
`endif
        end else if (cnt_sat) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      high_q     <= '0;
      period_q   <= '0;
      high_cnt_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_q     <= high_d;
      period_q   <= period_d;
      high_cnt_q <= high_cnt_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign valid    = valid_q;
  assign timeout  = timeout_q;
  assign period   = period_q;
  assign high_cnt = high_cnt_q;

endmodule

// File: doc/clk_ratio_meter.md
Name: clk_ratio_meter

Overview:
Measurement-side counterpart of the team's clock dividers. Samples an asynchronous divided-clock/pulse input `sig_in` on the system clock and reports its period and high time in `clk` cycles. Used on the board to check divider outputs and external tick sources. Single-shot measurement on `start`, with an optional continuous mode.

Parameters:
- WIDTH, 24, width of the cycle counter and result registers; max measurable count is 2^WIDTH-1.
- SYNC_STAGES, 2, synchronizer flops on `sig_in`; minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- sig_in  input  1  signal under measurement; asynchronous to clk.
- start  input  1  one-cycle request to begin a measurement; ignored while busy=1.
- busy  output  1  high from the cycle after an accepted start until DONE/timeout completes.
- valid  output  1  one-cycle pulse; period/high_cnt updated in that cycle.
- period  output  WIDTH  clk cycles between two consecutive rising edges of sig_in.
- high_cnt  output  WIDTH  clk cycles sig_in was high within that period.
- timeout  output  1  one-cycle pulse when a measurement is abandoned.

Behaviour:
- Reset (async, any state): state=IDLE; busy, valid and timeout = 0; period, high_cnt and cnt = 0; synchronizer flops = 0.
- Input path: SYNC_STAGES-flop synchronizer, then one edge-detect register. A `sig_in` change is detected SYNC_STAGES+1 cycles later. Latency is identical for rise and fall, so counts are unbiased.
- FSM states: IDLE, ARM, MEAS_HI, MEAS_LO.
  - IDLE: start=1 -> ARM. Edges are ignored.
  - ARM: wait for a detected rise. Edges in the same cycle as the start acceptance are not seen; detection begins the next cycle. On rise: cnt<=1 -> MEAS_HI.
  - MEAS_HI: cnt<=cnt+1 each cycle. On detected fall: high_q<=cnt -> MEAS_LO.
  - MEAS_LO: cnt<=cnt+1. On detected rise: period<=cnt, high_cnt<=high_q, valid=1 in the next cycle, -> IDLE.
- Arithmetic: for a clk-synchronous `sig_in` high H and low L cycles, period=H+L and high_cnt=H exactly.
- Result registers change only on a valid pulse.
- Timeout: in ARM, MEAS_HI or MEAS_LO, if cnt (ARM uses the same counter, cleared on entry) reaches 2^WIDTH-1 with no expected edge:
  - timeout=1 for one cycle, no valid.
  - period and high_cnt are unchanged.
  - -> IDLE.
- Simultaneous events:
  - An expected edge and the saturating count in the same cycle: the edge wins.
  - start while busy: ignored.
- busy=1 exactly while the state is not IDLE. It drops in the cycle valid or timeout is asserted.
- Glitches shorter than one clk period may be missed; this is not an error.

Optional Feature:
- Macro: CLK_RATIO_METER_CONT_EN.
- Defined:
  - The MEAS_LO terminating rise also restarts measurement: cnt<=1, -> MEAS_HI.
  - valid pulses once per sig_in period after the first full period, with no gaps.
  - start is still required once to leave IDLE. Timeout returns to IDLE.
- Undefined: single-shot behaviour as above.

Decomposition:
- Package clk_ratio_meter_pkg:
  - FSM state enum (2 bits).
  - Default WIDTH and SYNC_STAGES constants.
- Sub-module sync_edge_det (synchronizer + edge register):
  - Parameter SYNC_STAGES.
  - Outputs: sig_s, rise, fall.
  - Reusable by other blocks in the codebase.

Test Plan:
- Single shot, square wave:
  - Stimulus: reset; start; sig_in synchronous, H=2, L=2 (divide-by-4 shape).
  - Response: one valid pulse with period=4, high_cnt=2; busy low afterwards.
- Asymmetric input:
  - Stimulus: H=3, L=2.
  - Response: period=5, high_cnt=3. Repeat with H=1, L=1 -> period=2, high_cnt=1.
- Timeout:
  - Stimulus: WIDTH=8; start; sig_in held 0.
  - Response: timeout pulse after cnt reaches 255; no valid; period and high_cnt retain previous values.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during MEAS_LO.
  - Response: outputs and cnt are 0 immediately. After release, no valid appears without a new start.
- start while busy:
  - Stimulus: second start during MEAS_HI.
  - Response: ignored; exactly one valid pulse.
- Continuous mode:
  - Stimulus: CLK_RATIO_METER_CONT_EN defined; H=4, L=4 for 5 periods.
  - Response: 4 valid pulses spaced exactly 8 cycles apart, each with period=8, high_cnt=4.
